// File: rtl/shift_register_pkg.sv
// shift_register_pkg: shared mode and sequencer state types for the scan-chain register
package shift_register_pkg;
  typedef enum logic [1:0] {
    MODE_LOAD = 2'd0,
    MODE_SHL  = 2'd1,
    MODE_SHR  = 2'd2,
    MODE_ROL  = 2'd3
  } mode_t;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/shift_register_scan_chain_scan_lane.sv
// scan_lane: one LEN-bit scan lane with serial shift path, parallel-next load and MSB tap
module scan_lane #(
  parameter int LEN = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           shift,
  input  logic           load,
  input  logic           scan_in,
  input  logic [LEN-1:0] par_in,
  output logic [LEN-1:0] q,
  output logic           msb
);
  logic [LEN-1:0] shifted;
  if (LEN == 1) begin : g_one
    assign shifted = scan_in;
  end else begin : g_many
    assign shifted = {q[LEN-2:0], scan_in};
  end
  // lane shift wins over the functional next value; otherwise hold
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (shift) q <= shifted;
    else if (load) q <= par_in;
  assign msb = q[LEN-1];
endmodule

// File: rtl/shift_register_scan_chain.sv
// shift_register_scan_chain: shift register with load/shift/rotate modes and a sequenced multi-lane scan chain
module shift_register_scan_chain
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  input  logic             scan_enable,
  input  logic             scan_start,
  input  logic [LANES-1:0] scan_in,
  output logic [LANES-1:0] scan_out,
  output logic             scan_busy,
  output logic             scan_done
);
  localparam int LANE_LEN = WIDTH / LANES;
  localparam int CW = $clog2(LANE_LEN) + 1;
  if (WIDTH < 2 || WIDTH % LANES != 0) begin : g_bad_params
    $error("shift_register_scan_chain: WIDTH must be >= 2 and a multiple of LANES");
  end
  state_t state, state_next;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] func_next;
  logic free, lane_shift, lane_load;
  mode_t md;
  assign md = mode_t'(mode);
  // IDLE without a start request is the only state where manual scan and functional modes act
  assign free = state == ST_IDLE && !scan_start;
  assign lane_shift = state == ST_SHIFT || (free && scan_enable);
  assign lane_load = free && !scan_enable && enable;
  // functional next value selected by mode
  always_comb
    func_next = md == MODE_LOAD ? data_in :
                md == MODE_SHL  ? {data_out[WIDTH-2:0], serial_in} :
                md == MODE_SHR  ? {serial_in, data_out[WIDTH-1:1]} :
                                  {data_out[WIDTH-2:0], data_out[WIDTH-1]};
  // sequencer state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_next;
  // sequencer next state; DONE and any stray encoding return to IDLE
  always_comb
    state_next = state == ST_IDLE  ? (scan_start ? ST_SHIFT : ST_IDLE) :
                 state == ST_SHIFT ? (count == CW'(LANE_LEN - 1) ? ST_DONE : ST_SHIFT) :
                                     ST_IDLE;
  // shift counter: cleared on start, counts each automatic shift
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (state == ST_IDLE && scan_start) count <= '0;
    else if (state == ST_SHIFT) count <= count + CW'(1);
  assign scan_busy = state == ST_SHIFT;
  assign scan_done = state == ST_DONE;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    scan_lane #(.LEN(LANE_LEN)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .shift   (lane_shift),
      .load    (lane_load),
      .scan_in (scan_in[i]),
      .par_in  (func_next[i*LANE_LEN +: LANE_LEN]),
      .q       (data_out[i*LANE_LEN +: LANE_LEN]),
      .msb     (scan_out[i])
    );
  end
endmodule

// File: tb/tb_shift_register_scan_chain.sv
// tb_shift_register_scan_chain: vectors, scan sequences and a randomized model check over three configurations
module tb_shift_register_scan_chain;
  localparam int NW[3] = '{8, 8, 4};
  localparam int NL[3] = '{1, 2, 4};
  typedef struct {
    logic       en;
    logic [1:0] md;
    logic [7:0] din;
    logic       ser;
    logic       sen;
    logic       si;
    logic [7:0] exp;
  } vec_t;
  logic clk = 0, rst = 1;
  logic enable = 0, serial_in = 0, scan_enable = 0, scan_start = 0;
  logic [1:0] mode = 0;
  logic [7:0] din [3];
  logic [3:0] si [3];
  logic [7:0] d1_dout, d2_dout;
  logic [3:0] d4_dout;
  logic d1_so;
  logic [1:0] d2_so;
  logic [3:0] d4_so;
  logic busy [3];
  logic done [3];
  logic [7:0] o_d [3];
  logic [3:0] o_so [3];
  logic [7:0] m_d [3];
  int m_left [3];
  bit m_done [3];
  int checks = 0, passes = 0;
  always #5 clk = ~clk;
  shift_register_scan_chain #(.WIDTH(8), .LANES(1)) d1 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .data_in(din[0]), .serial_in(serial_in),
    .data_out(d1_dout), .scan_enable(scan_enable), .scan_start(scan_start), .scan_in(si[0][0]),
    .scan_out(d1_so), .scan_busy(busy[0]), .scan_done(done[0]));
  shift_register_scan_chain #(.WIDTH(8), .LANES(2)) d2 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .data_in(din[1]), .serial_in(serial_in),
    .data_out(d2_dout), .scan_enable(scan_enable), .scan_start(scan_start), .scan_in(si[1][1:0]),
    .scan_out(d2_so), .scan_busy(busy[1]), .scan_done(done[1]));
  shift_register_scan_chain #(.WIDTH(4), .LANES(4)) d4 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .data_in(din[2][3:0]), .serial_in(serial_in),
    .data_out(d4_dout), .scan_enable(scan_enable), .scan_start(scan_start), .scan_in(si[2]),
    .scan_out(d4_so), .scan_busy(busy[2]), .scan_done(done[2]));
  assign o_d[0] = d1_dout;
  assign o_d[1] = d2_dout;
  assign o_d[2] = {4'b0, d4_dout};
  assign o_so[0] = {3'b0, d1_so};
  assign o_so[1] = {2'b0, d2_so};
  assign o_so[2] = d4_so;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] lane_shift(int w, int lanes, logic [7:0] d, logic [3:0] s);
    int len = w / lanes;
    int m = (1 << len) - 1;
    logic [7:0] r = 0;
    for (int l = 0; l < lanes; l++) begin
      int lane;
      lane = (int'(d) >> (l * len)) & m;
      lane = ((lane << 1) | int'(s[l])) & m;
      r |= 8'(lane << (l * len));
    end
    return r;
  endfunction
  function automatic logic [7:0] func_op(int w, logic [1:0] md, logic [7:0] d, logic [7:0] di, logic s);
    int x = int'(d);
    case (md)
      2'd0: x = int'(di);
      2'd1: x = (x << 1) | int'(s);
      2'd2: x = (x >> 1) | (int'(s) << (w - 1));
      default: x = (x << 1) | (x >> (w - 1));
    endcase
    return 8'(x & ((1 << w) - 1));
  endfunction
  function automatic logic [3:0] lane_msbs(int w, int lanes, logic [7:0] d);
    int len = w / lanes;
    logic [3:0] r = 0;
    for (int l = 0; l < lanes; l++) r[l] = d[(l + 1) * len - 1];
    return r;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_d[k] = 0;
      m_left[k] = 0;
      m_done[k] = 0;
    end
  endtask
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (m_left[k] > 0) begin
        m_d[k] = lane_shift(NW[k], NL[k], m_d[k], si[k]);
        m_left[k]--;
        if (m_left[k] == 0) m_done[k] = 1;
      end else if (m_done[k]) m_done[k] = 0;
      else if (scan_start) m_left[k] = NW[k] / NL[k];
      else if (scan_enable) m_d[k] = lane_shift(NW[k], NL[k], m_d[k], si[k]);
      else if (enable) m_d[k] = func_op(NW[k], mode, m_d[k], din[k], serial_in);
    end
  endtask
  initial begin
    vec_t vecs [8];
    logic [3:0] e0, e1;
    int nb, nd;
    vecs = '{
      '{1'b1, 2'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5},
      '{1'b1, 2'd1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h4B},
      '{1'b1, 2'd3, 8'h00, 1'b0, 1'b0, 1'b0, 8'h96},
      '{1'b1, 2'd2, 8'h00, 1'b0, 1'b0, 1'b0, 8'h4B},
      '{1'b0, 2'd0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h4B},
      '{1'b1, 2'd0, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81},
      '{1'b1, 2'd0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h02},
      '{1'b1, 2'd0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h04}
    };
    for (int k = 0; k < 3; k++) begin
      din[k] = 0;
      si[k] = 0;
    end
    model_reset();
    #12;
    for (int k = 0; k < 3; k++)
      check($sformatf("reset dut%0d", k), {o_d[k], o_so[k], busy[k], done[k]}, 0);
    @(negedge clk);
    rst = 0;
    step();
    for (int i = 0; i < 8; i++) begin
      enable = vecs[i].en;
      mode = vecs[i].md;
      din[0] = vecs[i].din;
      serial_in = vecs[i].ser;
      scan_enable = vecs[i].sen;
      si[0] = {3'b0, vecs[i].si};
      step();
      check($sformatf("vec%0d data", i), d1_dout, vecs[i].exp);
      check($sformatf("vec%0d busy", i), busy[0], 0);
    end
    scan_enable = 0;
    enable = 1;
    mode = 0;
    din[0] = 8'hA5;
    din[1] = 8'hA5;
    din[2] = 8'h00;
    step();
    enable = 0;
    scan_start = 1;
    si[0] = 4'h1;
    si[1] = 4'h3;
    si[2] = 4'b1010;
    step();
    scan_start = 0;
    e0 = 4'b1010;
    e1 = 4'b0101;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("auto busy c%0d", i), busy[1], 1);
      check($sformatf("auto scan_out c%0d", i), d2_so, {e1[i-1], e0[i-1]});
      if (i == 1) check("lane1 busy", {busy[2], done[2]}, 2'b10);
      if (i == 2) check("lane1 done", {busy[2], done[2], d4_dout}, {2'b01, 4'hA});
      step();
    end
    check("auto done", {busy[1], done[1]}, 2'b01);
    check("auto data", d2_dout, 8'hFF);
    step();
    check("auto done once", done[1], 0);
    repeat (10) step();
    enable = 1;
    din[1] = 8'hA5;
    step();
    enable = 0;
    scan_start = 1;
    si[1] = 4'h3;
    step();
    nb = 0;
    nd = 0;
    for (int i = 1; i <= 9; i++) begin
      nb += int'(busy[1]);
      nd += int'(done[1]);
      enable = i <= 5;
      mode = 0;
      din[1] = 0;
      scan_enable = i <= 5;
      scan_start = i <= 5;
      step();
    end
    check("ignore busy cycles", nb, 4);
    check("ignore done pulses", nd, 1);
    check("ignore data", d2_dout, 8'hFF);
    repeat (10) step();
    enable = 1;
    mode = 0;
    din[1] = 8'hA5;
    step();
    enable = 0;
    scan_start = 1;
    step();
    scan_start = 0;
    step();
    check("pre-reset busy", busy[1], 1);
    #3 rst = 1;
    #1;
    check("midscan reset data", d2_dout, 0);
    check("midscan reset flags", {busy[0], busy[1], busy[2], done[0], done[1], done[2]}, 0);
    model_reset();
    #2 rst = 0;
    nd = 0;
    repeat (8) begin
      step();
      nd += int'(done[0]) + int'(done[1]) + int'(done[2]);
    end
    check("no done after reset", nd, 0);
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++)
        check($sformatf("rand c%0d dut%0d", c, k), {o_d[k], o_so[k], busy[k], done[k]},
              {m_d[k], lane_msbs(NW[k], NL[k], m_d[k]), m_left[k] > 0, m_done[k]});
      enable = 1'($urandom_range(0, 1));
      mode = 2'($urandom);
      serial_in = 1'($urandom_range(0, 1));
      scan_enable = $urandom_range(0, 3) == 0;
      scan_start = $urandom_range(0, 9) == 0;
      for (int k = 0; k < 3; k++) begin
        din[k] = 8'($urandom);
        si[k] = 4'($urandom);
      end
      model_step();
      step();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
